// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

   localparam int EX_TO_MEM_WD = 81;
   localparam int MEM_TO_WB_WD = 70;
   localparam int MEM_TO_RF_WD = 38;
   localparam int STALL_BUS    = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Stall vector bit positions
   localparam int STALL_MEM = 3;
   localparam int STALL_WB  = 4;

   // One-hot mem_op bit positions, {lb, lbu, lh, lhu, lw}
   localparam int MEM_OP_LW  = 0;
   localparam int MEM_OP_LHU = 1;
   localparam int MEM_OP_LH  = 2;
   localparam int MEM_OP_LBU = 3;
   localparam int MEM_OP_LB  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HELD = 2'd2
   } rsp_state_e;

   // Execute-to-memory bus; first field is the MSB
   typedef struct packed {
      logic [4:0]  mem_op;
      logic [31:0] pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword and extends it.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [4:0]  mem_op_i,
   input  logic [1:0]  off_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed lane, then extend according to the load type
   always_comb begin
      byte_sel = word_i[7:0];
      case (off_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

      result_o = 32'h0;
      if (mem_op_i[MEM_OP_LB])
         result_o = {{24{byte_sel[7]}}, byte_sel};
      else if (mem_op_i[MEM_OP_LBU])
         result_o = {24'h0, byte_sel};
      else if (mem_op_i[MEM_OP_LH])
         result_o = {{16{half_sel[15]}}, half_sel};
      else if (mem_op_i[MEM_OP_LHU])
         result_o = {16'h0, half_sel};
      else if (mem_op_i[MEM_OP_LW])
         result_o = word_i;
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: stage register, load-response FSM with a one-word
// buffer for responses that arrive while frozen, and result forwarding.
//
// state | meaning
// IDLE  | no response outstanding (or load completing this cycle)
// WAIT  | load in stage, SRAM response not yet seen
// HELD  | response captured in rbuf while the stage was frozen
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_BUS-1:0]    stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   input  logic                    data_sram_rvalid,
   output logic                    stallreq,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

   ex_to_mem_t ex_q, ex_d;
   rsp_state_e state_q, state_d;
   logic [31:0] rbuf_q, rbuf_d;

   logic        is_load;
   logic [31:0] load_word;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;
   logic        unused_stall;

   assign is_load      = (ex_q.mem_op != 5'd0) && ex_q.data_ram_en;
   assign unused_stall = ^{stall[5], stall[2:0], ex_q.data_ram_wen};

   // State register: stage register, response FSM and response buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q    <= '0;
         state_q <= ST_IDLE;
         rbuf_q  <= 32'h0;
      end else begin
         ex_q    <= ex_d;
         state_q <= state_d;
         rbuf_q  <= rbuf_d;
      end
   end

   // Next-state logic for the stage register and the response FSM
   always_comb begin
      ex_d    = ex_q;
      state_d = state_q;
      rbuf_d  = rbuf_q;

      if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP)
         ex_d = '0;
      else if (stall[STALL_MEM] == NO_STOP)
         ex_d = ex_to_mem_bus;

      case (state_q)
         ST_IDLE: begin
            if (is_load) begin
               if (!data_sram_rvalid) begin
                  state_d = ST_WAIT;
               end else if (stall[STALL_MEM] == STOP) begin
                  state_d = ST_HELD;
                  rbuf_d  = data_sram_rdata;
               end
            end
         end
         ST_WAIT: begin
            // A bubble overwrote the load: nothing left to wait for
            if (!is_load) begin
               state_d = ST_IDLE;
            end else if (data_sram_rvalid) begin
               if (stall[STALL_MEM] == STOP) begin
                  state_d = ST_HELD;
                  rbuf_d  = data_sram_rdata;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_HELD: begin
            if (stall[STALL_MEM] == NO_STOP)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   load_align u_load_align (
      .word_i   (load_word),
      .mem_op_i (ex_q.mem_op),
      .off_i    (ex_q.ex_result[1:0]),
      .result_o (load_data)
   );

   // Output logic: data source select, stall request and result buses
   always_comb begin
      load_word     = (state_q == ST_HELD) ? rbuf_q : data_sram_rdata;
      stallreq      = is_load && (state_q != ST_HELD) && !data_sram_rvalid;
      rf_wdata      = ex_q.sel_rf_res ? load_data : ex_q.ex_result;
      mem_to_rf_bus = {ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
      mem_to_wb_bus = {ex_q.pc, ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected write-back words.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [80:0] ex_bus;
   logic [31:0] rdata;
   logic        rvalid;
   logic        stallreq;
   logic [69:0] wb;
   logic [37:0] rf;
   logic        ext_stop;
   logic        ext_bubble;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [69:0] exp_q[$];
   bit          occ = 1'b0;

   // Minimal stall controller: a memory stall freezes everything up to write-back
   assign stall = (stallreq || ext_stop) ? 6'b011111 :
                  ext_bubble             ? 6'b001111 : 6'b000000;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .ex_to_mem_bus    (ex_bus),
      .data_sram_rdata  (rdata),
      .data_sram_rvalid (rvalid),
      .stallreq         (stallreq),
      .mem_to_wb_bus    (wb),
      .mem_to_rf_bus    (rf)
   );

   localparam logic [4:0] OP_LB  = 5'b10000;
   localparam logic [4:0] OP_LBU = 5'b01000;
   localparam logic [4:0] OP_LH  = 5'b00100;
   localparam logic [4:0] OP_LHU = 5'b00010;
   localparam logic [4:0] OP_LW  = 5'b00001;

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_align(input logic [4:0] op, input logic [1:0] off,
                                             input logic [31:0] w);
      logic [31:0] sb;
      logic [31:0] sh;
      sb = w >> (off * 8);
      sh = w >> (off[1] * 16);
      case (op)
         OP_LB:   return {{24{sb[7]}}, sb[7:0]};
         OP_LBU:  return {24'h0, sb[7:0]};
         OP_LH:   return {{16{sh[15]}}, sh[15:0]};
         OP_LHU:  return {16'h0, sh[15:0]};
         OP_LW:   return w;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] pc,
                                      input logic en, input logic sel, input logic we,
                                      input logic [4:0] waddr, input logic [31:0] res);
      return {op, pc, en, 4'b0000, sel, we, waddr, res};
   endfunction

   function automatic logic [69:0] wbv(input logic [31:0] pc, input logic we,
                                       input logic [4:0] waddr, input logic [31:0] wdata);
      return {pc, we, waddr, wdata};
   endfunction

   // One clock: check at the falling edge, advance the occupancy model at the rising edge
   task automatic cycle(input bit exp_sr, input string tag);
      logic [5:0]  st;
      logic [69:0] e;
      @(negedge clk);
      st = stall;
      chk({tag, "/stallreq"}, 70'(stallreq), 70'(exp_sr));
      if (occ && st[3] == 1'b0) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL %s: observed output %h expected empty scoreboard", tag, wb);
         end else begin
            e = exp_q.pop_front();
            chk({tag, "/wb"}, wb, e);
            chk({tag, "/rf"}, 70'(rf), 70'(e[37:0]));
         end
      end else if (!occ) begin
         chk({tag, "/bubble"}, wb, 70'h0);
      end
      @(posedge clk);
      if (st[3] == 1'b0)      occ = (ex_bus != 81'h0);
      else if (st[4] == 1'b0) occ = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b0; ex_bus = '0; rdata = '0; rvalid = 1'b0;
      ext_stop = 1'b0; ext_bubble = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset/stallreq", 70'(stallreq), 70'h0);
      chk("reset/wb", wb, 70'h0);
      chk("reset/rf", 70'(rf), 70'h0);
      @(posedge clk); #1 rst = 1'b0;

      // Back-to-back sub-word loads, single-cycle SRAM
      rdata = 32'h8899AABB; rvalid = 1'b1;
      ex_bus = mk(OP_LB, 32'h100, 1, 1, 1, 5'd3, 32'h1001);
      exp_q.push_back(wbv(32'h100, 1, 5'd3, ref_align(OP_LB, 2'd1, rdata)));
      cycle(0, "lb_load");
      ex_bus = mk(OP_LHU, 32'h104, 1, 1, 1, 5'd4, 32'h1002);
      exp_q.push_back(wbv(32'h104, 1, 5'd4, ref_align(OP_LHU, 2'd2, rdata)));
      cycle(0, "lb");
      ex_bus = mk(OP_LH, 32'h108, 1, 1, 1, 5'd5, 32'h1000);
      exp_q.push_back(wbv(32'h108, 1, 5'd5, ref_align(OP_LH, 2'd0, rdata)));
      cycle(0, "lhu");
      ex_bus = mk(OP_LBU, 32'h10C, 1, 1, 1, 5'd6, 32'h1003);
      exp_q.push_back(wbv(32'h10C, 1, 5'd6, ref_align(OP_LBU, 2'd3, rdata)));
      cycle(0, "lh");
      ex_bus = '0;
      cycle(0, "lbu");
      rvalid = 1'b0;

      // lw with the response three cycles late
      rdata = 32'hCAFEF00D;
      ex_bus = mk(OP_LW, 32'h200, 1, 1, 1, 5'd7, 32'h2000);
      exp_q.push_back(wbv(32'h200, 1, 5'd7, 32'hCAFEF00D));
      cycle(0, "lw_load");
      ex_bus = '0;
      cycle(1, "lw_w1");
      cycle(1, "lw_w2");
      cycle(1, "lw_w3");
      rvalid = 1'b1;
      cycle(0, "lw_done");
      rvalid = 1'b0;

      // Response arrives while frozen; SRAM data then changes
      ex_bus = mk(OP_LW, 32'h300, 1, 1, 1, 5'd9, 32'h3004);
      exp_q.push_back(wbv(32'h300, 1, 5'd9, 32'h12345678));
      cycle(0, "held_load");
      ex_bus = '0; ext_stop = 1'b1; rvalid = 1'b1; rdata = 32'h12345678;
      cycle(0, "held_s1");
      rvalid = 1'b0; rdata = 32'hDEADBEEF;
      cycle(0, "held_s2");
      ext_stop = 1'b0;
      cycle(0, "held_out");

      // Asynchronous reset in WAIT, then a stray response
      ex_bus = mk(OP_LW, 32'h400, 1, 1, 1, 5'd10, 32'h4000);
      cycle(0, "rst_load");
      ex_bus = '0;
      cycle(1, "rst_wait");
      #1 rst = 1'b1;
      #1;
      chk("midrst/stallreq", 70'(stallreq), 70'h0);
      chk("midrst/wb", wb, 70'h0);
      chk("midrst/rf", 70'(rf), 70'h0);
      rst = 1'b0; occ = 1'b0;
      rvalid = 1'b1; rdata = 32'hBAD0BAD0;
      cycle(0, "stray");
      rvalid = 1'b0;
      ex_bus = mk(OP_LB, 32'h500, 1, 1, 1, 5'd11, 32'h5002);
      exp_q.push_back(wbv(32'h500, 1, 5'd11, ref_align(OP_LB, 2'd2, 32'h00F00000)));
      cycle(0, "post_load");
      ex_bus = '0;
      cycle(1, "post_wait");
      rvalid = 1'b1; rdata = 32'h00F00000;
      cycle(0, "post_out");
      rvalid = 1'b0;

      // Bubble insertion ahead of an ALU result
      ex_bus = mk(5'b00000, 32'h600, 0, 0, 1, 5'd2, 32'h5);
      exp_q.push_back(wbv(32'h600, 1, 5'd2, 32'h5));
      ext_bubble = 1'b1;
      cycle(0, "bub1");
      cycle(0, "bub2");
      ext_bubble = 1'b0;
      cycle(0, "bub3");
      ex_bus = '0;
      cycle(0, "add_out");
      cycle(0, "idle");
      chk("sb_empty", 70'(exp_q.size()), 70'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage MIPS core, directly downstream of the execute stage. Registers the execute-to-memory bus under the global stall vector, waits for the data SRAM read response of loads, and aligns and extends the returned word for lb/lbu/lh/lhu/lw. Forwards the final write-back value to decode and sends the result on to write-back. Buffers a load response that arrives while the pipeline is frozen, so no data is lost.

## Interface
- No parameters. Widths come from `lib/defines.vh`: `EX_TO_MEM_WD`=81, `MEM_TO_WB_WD`=70, `MEM_TO_RF_WD`=38, `StallBus`=6.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  stage clock
- rst  in  1  asynchronous, active-high reset
- stall  in  `StallBus`  global stall vector; bit 3 = this stage, bit 4 = write-back
- ex_to_mem_bus  in  81  {mem_op[4:0], pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}
- data_sram_rdata  in  32  read data from the data SRAM
- data_sram_rvalid  in  1  read data valid; one pulse per load request
- stallreq  out  1  stall request to the controller while a load response is outstanding
- mem_to_wb_bus  out  70  {pc, rf_we, rf_waddr, rf_wdata}
- mem_to_rf_bus  out  38  {rf_we, rf_waddr, rf_wdata}, forwarding to decode

## Operation
- Stage register update rules:
  - stall[3]=Stop and stall[4]=NoStop: load a bubble (all zero).
  - stall[3]=NoStop: load ex_to_mem_bus.
  - Otherwise: hold.
- mem_op one-hot {lb, lbu, lh, lhu, lw}. The instruction is a load when mem_op≠0 and data_ram_en=1. Stores and ALU results pass straight through with no wait.
- Byte offset `off` = ex_result[1:0].
- Load alignment of word `w`:
  - lb: byte `off`, sign-extended.
  - lbu: byte `off`, zero-extended.
  - lh: halfword off[1] (0 = bits 15:0, 1 = bits 31:16), sign-extended.
  - lhu: same halfword, zero-extended.
  - lw: `w` unchanged.
- rf_wdata = sel_rf_res ? aligned load data : ex_result.
- Response FSM (states IDLE, WAIT, HELD):
  - IDLE to WAIT: a load enters the register and data_sram_rvalid=0 in its first cycle.
  - IDLE to HELD: a load is present, rvalid=1, and stall[3]=Stop. Capture rdata into rbuf.
  - WAIT to HELD: rvalid=1 and stall[3]=Stop. Capture into rbuf.
  - WAIT to IDLE: rvalid=1 and stall[3]=NoStop. The load leaves using the live rdata.
  - HELD to IDLE: stall[3]=NoStop. The load leaves using rbuf.
  - In HELD, `w` = rbuf. Otherwise `w` = data_sram_rdata.
- stallreq=1 exactly when a load is present, the state is not HELD, and rvalid=0.
- rvalid in IDLE with no load present (a stale response after reset) is ignored.
- Bubble outputs: all-zero buses, so rf_we=0.

## Timing
- Reset (asynchronous): stage register 0, state IDLE, rbuf 0. stallreq=0; mem_to_wb_bus=0; mem_to_rf_bus=0 immediately, without a clock.
- Reset asserted mid-WAIT or mid-HELD: the pending load is discarded and any later rvalid is ignored.
- Latency: one cycle from stage-register load to the outputs, when rvalid arrives in that same cycle (single-cycle SRAM).
- Extra latency: each cycle without rvalid adds one stall cycle.
- Output paths: all outputs except the registered state are combinational from the stage register, rbuf and the SRAM inputs, and valid in the same cycle.
- Stall source: stallreq never depends on stall[3], which avoids a combinational loop through the controller.
- Back-to-back loads: the second load's response is accepted only after the first has left. One outstanding request per load, in order.

## Structure
- Add to `lib/defines.vh`:
  - `EX_TO_MEM_WD`, `MEM_TO_WB_WD`, `MEM_TO_RF_WD`
  - mem_op bit positions `MemOpLb`..`MemOpLw`
  - FSM state encodings
- Existing `Stop`/`NoStop` are reused.
- One natural sub-module, `load_align`: combinational word plus mem_op plus offset to 32-bit result. Keep it separate so it can be unit-tested exhaustively.

## Test plan
- lb, off=1, rdata 0x8899AABB, rvalid in the first cycle -> rf_wdata 0xFFFFFFAA, stallreq never 1.
- lhu, off=2, same word -> 0x00008899. lh, off=0 -> 0xFFFFAABB. lbu, off=3 -> 0x00000088.
- lw with rvalid delayed 3 cycles -> stallreq high for exactly 3 cycles; rf_wdata = rdata on the 4th cycle; the stage register holds.
- rvalid=1 with 0x12345678 while stall[3]=Stop for 2 cycles, SRAM rdata then changed to 0xDEADBEEF -> the load leaves with 0x12345678 from rbuf.
- rst pulsed asynchronously mid-WAIT, then a stray rvalid -> outputs 0 at once, state IDLE, stray response ignored, no stallreq.
- stall[3]=Stop and stall[4]=NoStop with an add (ex_result 0x5) in EX -> a bubble is issued (mem_to_wb_bus=0), then 0x5 on the next unstalled cycle.
